// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serialises valid/ready bitstream words MSB-first onto a ccff configuration chain.
// Optional readback of the previous chain contents is built when CCFF_CHAIN_LOADER_READBACK_EN is defined.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 1024,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  ,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid
`endif
);

  localparam int NB_W = $clog2(WORD_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WORD_W-1:0] r_buf;
  logic [NB_W-1:0]   r_nbits;
  logic [CNT_W-1:0]  r_cnt;

  logic w_enter;
  logic w_shift;
  logic w_last;
  logic w_ready;
  logic w_accept;

  always_comb begin
    w_enter  = start && (r_state != S_LOAD);
    w_shift  = (r_state == S_LOAD) && (r_nbits != '0);
    w_last   = w_shift && (r_cnt == CNT_W'(CHAIN_LEN - 1));
    // A refill may overlap the final buffered bit, except when that bit ends the chain.
    w_ready  = (r_state == S_LOAD) &&
               ((r_nbits == '0) || (w_shift && (r_nbits == NB_W'(1)) && !w_last));
    w_accept = word_valid && w_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_LOAD;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_buf   <= '0;
      r_nbits <= '0;
      r_cnt   <= '0;
    end else if (w_enter) begin
      r_buf   <= '0;
      r_nbits <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_buf   <= word_data;
        r_nbits <= NB_W'(WORD_W);
      end else if (w_last) begin
        // Leftover low bits of a truncated final word are dropped here.
        r_buf   <= '0;
        r_nbits <= '0;
      end else if (w_shift) begin
        r_buf   <= {r_buf[WORD_W-2:0], 1'b0};
        r_nbits <= r_nbits - NB_W'(1);
      end
      if (w_shift && (r_cnt != CNT_W'(CHAIN_LEN)))
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign word_ready    = w_ready;
  assign ccff_head     = r_buf[WORD_W-1];
  assign ccff_shift_en = w_shift;
  assign busy          = (r_state == S_LOAD);
  assign done          = (r_state == S_DONE);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [WORD_W-1:0] r_rb_acc;
  logic [WORD_W-1:0] r_rb_data;
  logic [NB_W-1:0]   r_rb_idx;
  logic              r_rb_valid;
  logic [WORD_W-1:0] w_rb_next;
  logic [NB_W-1:0]   w_rb_pad;

  always_comb begin
    w_rb_next = {r_rb_acc[WORD_W-2:0], ccff_tail};
    w_rb_pad  = NB_W'(WORD_W - 1) - r_rb_idx;
  end

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_rb_acc   <= '0;
      r_rb_data  <= '0;
      r_rb_idx   <= '0;
      r_rb_valid <= 1'b0;
    end else begin
      r_rb_valid <= 1'b0;
      if (w_enter) begin
        r_rb_acc <= '0;
        r_rb_idx <= '0;
      end else if (w_shift) begin
        if ((r_rb_idx == NB_W'(WORD_W - 1)) || w_last) begin
          // Partial final word is left-aligned so its unused LSBs read as zero.
          r_rb_data  <= w_rb_next << w_rb_pad;
          r_rb_valid <= 1'b1;
          r_rb_acc   <= '0;
          r_rb_idx   <= '0;
        end else begin
          r_rb_acc <= w_rb_next;
          r_rb_idx <= r_rb_idx + NB_W'(1);
        end
      end
    end
  end

  assign rb_data  = r_rb_data;
  assign rb_valid = r_rb_valid;
`else
  logic w_unused_tail;
  assign w_unused_tail = ccff_tail;
`endif

endmodule
